// File: rtl/tick_evt_pkg.sv
// tick_evt_pkg: event type encoding and default parameters shared by the tick event FIFO
package tick_evt_pkg;
    typedef enum logic [1:0] {NONE = 2'd0, MAX = 2'd1, MIN = 2'd2, BOTH = 2'd3} evt_type_e;
    localparam int DEF_N     = 8;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_SEQ_W = 8;
    localparam int DEF_TS_W  = 16;
endpackage

// File: rtl/tick_evt_mem.sv
// tick_evt_mem: DEPTH x W storage, one write port, combinational read, no reset
module tick_evt_mem #(
    parameter int W     = 18,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [W-1:0]             wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/tick_event_fifo.sv
// tick_event_fifo: FWFT queue of counter wrap events with sequence numbers and sticky overflow
// Define TICK_EVT_TS_EN to add a free-running timestamp captured with each entry (port evt_ts).
module tick_event_fifo
    import tick_evt_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH,
    parameter int SEQ_W = DEF_SEQ_W,
    parameter int TS_W  = DEF_TS_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0]             cnt_in,
    input  logic                     max_tick,
    input  logic                     min_tick,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [1:0]               evt_type,
    output logic [N-1:0]             evt_cnt,
    output logic [SEQ_W-1:0]         evt_seq,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
`ifdef TICK_EVT_TS_EN
    output logic [TS_W-1:0]          evt_ts,
`endif
    input  logic                     clr_ovf
);
    localparam int AW = $clog2(DEPTH);
`ifdef TICK_EVT_TS_EN
    localparam int TS_EN = 1;
`else
    localparam int TS_EN = 0;
`endif
    localparam int EW = 2 + N + SEQ_W + TS_W * TS_EN;
    logic [AW:0]      wr_ptr, rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic [EW-1:0]    wdata, rdata;
    logic             evt, pop, push;
    evt_type_e        etype;
    assign etype     = evt_type_e'({min_tick, max_tick});
    assign evt       = max_tick | min_tick;
    assign level     = wr_ptr - rd_ptr;
    assign full      = level == (AW + 1)'(DEPTH);
    assign empty     = level == '0;
    assign evt_valid = !empty;
    assign pop       = evt_valid & evt_ready;
    // a pop frees the slot this cycle, so a full FIFO can still accept
    assign push      = evt & (!full | pop);
    assign evt_type  = empty ? '0 : rdata[EW-1 -: 2];
    assign evt_cnt   = empty ? '0 : rdata[EW-3 -: N];
    assign evt_seq   = empty ? '0 : rdata[EW-3-N -: SEQ_W];
`ifdef TICK_EVT_TS_EN
    logic [TS_W-1:0] ts;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ts <= '0;
        else ts <= ts + 1'b1;
    assign wdata  = {etype, cnt_in, seq, ts};
    assign evt_ts = empty ? '0 : rdata[TS_W-1:0];
`else
    assign wdata  = {etype, cnt_in, seq};
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (evt) seq <= seq + 1'b1;
            overflow <= (evt && full && !pop) ? 1'b1 : clr_ovf ? 1'b0 : overflow;
        end
    tick_evt_mem #(.W(EW), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wdata),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_tick_event_fifo.sv
// tb_tick_event_fifo: directed self-checking bench for tick_event_fifo (DEPTH=8, N=8, SEQ_W=8)
module tb_tick_event_fifo;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] cnt_in = '0;
    logic       max_tick = 1'b0, min_tick = 1'b0, evt_ready = 1'b0, clr_ovf = 1'b0;
    logic       evt_valid, full, empty, overflow;
    logic [1:0] evt_type;
    logic [7:0] evt_cnt, evt_seq;
    logic [3:0] level;
`ifdef TICK_EVT_TS_EN
    logic [15:0] evt_ts;
`endif
    int n_chk = 0;
    int n_fail = 0;

    tick_event_fifo dut (
        .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .max_tick(max_tick), .min_tick(min_tick),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_type(evt_type), .evt_cnt(evt_cnt),
        .evt_seq(evt_seq), .level(level), .full(full), .empty(empty), .overflow(overflow),
`ifdef TICK_EVT_TS_EN
        .evt_ts(evt_ts),
`endif
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        max_tick = 0; min_tick = 0; evt_ready = 0; clr_ovf = 0; cnt_in = '0;
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic push_evt(input logic [7:0] c);
        cnt_in = c; max_tick = 1;
        tick();
        max_tick = 0;
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %0h exp 0", evt_valid); end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %0h exp 1", empty); end
        n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got %0h exp 0", full); end
        n_chk++; if (level !== 4'd0) begin n_fail++; $display("FAIL reset_level got %0d exp 0", level); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %0h exp 0", overflow); end
        n_chk++; if ({evt_type, evt_cnt, evt_seq} !== 18'd0) begin n_fail++; $display("FAIL reset_head got %0h exp 0", {evt_type, evt_cnt, evt_seq}); end
        tick();
        rst_n = 1;
    endtask

    task automatic test_single();
        do_reset();
        cnt_in = 8'hFF; max_tick = 1;
        n_chk++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pre_valid got %0h exp 0", evt_valid); end
        tick();
        max_tick = 0; cnt_in = 8'h12;
        n_chk++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid got %0h exp 1", evt_valid); end
        n_chk++; if (evt_type !== 2'd1) begin n_fail++; $display("FAIL single_type got %0d exp 1", evt_type); end
        n_chk++; if (evt_cnt !== 8'hFF) begin n_fail++; $display("FAIL single_cnt got %0h exp ff", evt_cnt); end
        n_chk++; if (evt_seq !== 8'd0) begin n_fail++; $display("FAIL single_seq got %0d exp 0", evt_seq); end
        n_chk++; if (level !== 4'd1) begin n_fail++; $display("FAIL single_level got %0d exp 1", level); end
        tick();
        n_chk++; if (level !== 4'd1 || evt_cnt !== 8'hFF) begin n_fail++; $display("FAIL single_hold got level %0d cnt %0h exp 1 ff", level, evt_cnt); end
        evt_ready = 1;
        tick();
        evt_ready = 0;
        n_chk++; if (empty !== 1'b1 || evt_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop got empty %0h valid %0h exp 1 0", empty, evt_valid); end
    endtask

    task automatic test_both_min();
        do_reset();
        cnt_in = 8'h00; max_tick = 1; min_tick = 1;
        tick();
        max_tick = 0; min_tick = 0;
        n_chk++; if (evt_type !== 2'd3) begin n_fail++; $display("FAIL both_type got %0d exp 3", evt_type); end
        n_chk++; if (level !== 4'd1) begin n_fail++; $display("FAIL both_level got %0d exp 1", level); end
        n_chk++; if (evt_cnt !== 8'h00 || evt_seq !== 8'd0) begin n_fail++; $display("FAIL both_head got cnt %0h seq %0d exp 0 0", evt_cnt, evt_seq); end
        cnt_in = 8'h05; min_tick = 1;
        tick();
        min_tick = 0; evt_ready = 1;
        n_chk++; if (level !== 4'd2) begin n_fail++; $display("FAIL min_level got %0d exp 2", level); end
        tick();
        evt_ready = 0;
        n_chk++; if (evt_type !== 2'd2) begin n_fail++; $display("FAIL min_type got %0d exp 2", evt_type); end
        n_chk++; if (evt_cnt !== 8'h05 || evt_seq !== 8'd1) begin n_fail++; $display("FAIL min_head got cnt %0h seq %0d exp 5 1", evt_cnt, evt_seq); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_seq [8] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd9};
        logic [7:0] exp_cnt [8] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hA0};
        do_reset();
        for (int i = 0; i < 9; i++) push_evt(8'(i));
        n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %0h exp 1", full); end
        n_chk++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_level got %0d exp 8", level); end
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag got %0h exp 1", overflow); end
        n_chk++; if (evt_seq !== 8'd0 || evt_cnt !== 8'd0) begin n_fail++; $display("FAIL ovf_head got seq %0d cnt %0h exp 0 0", evt_seq, evt_cnt); end
        evt_ready = 1;
        tick();
        evt_ready = 0;
        n_chk++; if (level !== 4'd7 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_pop got level %0d ovf %0h exp 7 1", level, overflow); end
        push_evt(8'hA0);
        n_chk++; if (level !== 4'd8) begin n_fail++; $display("FAIL ovf_refill got %0d exp 8", level); end
        evt_ready = 1;
        for (int i = 0; i < 8; i++) begin
            n_chk++; if (evt_seq !== exp_seq[i] || evt_cnt !== exp_cnt[i]) begin n_fail++; $display("FAIL ovf_drain%0d got seq %0d cnt %0h exp %0d %0h", i, evt_seq, evt_cnt, exp_seq[i], exp_cnt[i]); end
            tick();
        end
        evt_ready = 0;
        n_chk++; if (empty !== 1'b1 || evt_seq !== 8'd0) begin n_fail++; $display("FAIL ovf_empty got empty %0h seq %0d exp 1 0", empty, evt_seq); end
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear got %0h exp 0", overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) push_evt(8'(8'h10 + i));
        cnt_in = 8'h55; max_tick = 1; evt_ready = 1;
        tick();
        max_tick = 0; evt_ready = 0;
        n_chk++; if (level !== 4'd8 || full !== 1'b1) begin n_fail++; $display("FAIL fpp_level got %0d full %0h exp 8 1", level, full); end
        n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf got %0h exp 0", overflow); end
        n_chk++; if (evt_seq !== 8'd1 || evt_cnt !== 8'h11) begin n_fail++; $display("FAIL fpp_head got seq %0d cnt %0h exp 1 11", evt_seq, evt_cnt); end
        max_tick = 1; clr_ovf = 1;
        tick();
        max_tick = 0; clr_ovf = 0;
        n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL set_over_clr got %0h exp 1", overflow); end
        n_chk++; if (level !== 4'd8 || evt_seq !== 8'd1) begin n_fail++; $display("FAIL drop_unchanged got level %0d seq %0d exp 8 1", level, evt_seq); end
    endtask

    task automatic test_empty_push_pop();
        do_reset();
        cnt_in = 8'h3C; max_tick = 1; evt_ready = 1;
        tick();
        max_tick = 0; evt_ready = 0;
        n_chk++; if (level !== 4'd1 || evt_cnt !== 8'h3C || evt_seq !== 8'd0) begin n_fail++; $display("FAIL epp got level %0d cnt %0h seq %0d exp 1 3c 0", level, evt_cnt, evt_seq); end
    endtask

    task automatic test_seq_wrap();
        do_reset();
        evt_ready = 1; max_tick = 1;
        for (int i = 0; i < 256; i++) begin cnt_in = 8'(i); tick(); end
        evt_ready = 0;
        n_chk++; if (level !== 4'd1 || evt_seq !== 8'd255) begin n_fail++; $display("FAIL wrap255 got level %0d seq %0d exp 1 255", level, evt_seq); end
        evt_ready = 1;
        tick();
        max_tick = 0; evt_ready = 0;
        n_chk++; if (level !== 4'd1 || evt_seq !== 8'd0) begin n_fail++; $display("FAIL wrap0 got level %0d seq %0d exp 1 0", level, evt_seq); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) push_evt(8'(i));
        n_chk++; if (level !== 4'd5) begin n_fail++; $display("FAIL mid_level got %0d exp 5", level); end
        #2 rst_n = 0;
        #1;
        n_chk++; if (evt_valid !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL mid_async got valid %0h empty %0h exp 0 1", evt_valid, empty); end
        tick();
        rst_n = 1;
        push_evt(8'h77);
        n_chk++; if (evt_seq !== 8'd0 || level !== 4'd1) begin n_fail++; $display("FAIL mid_seq got seq %0d level %0d exp 0 1", evt_seq, level); end
    endtask

`ifdef TICK_EVT_TS_EN
    task automatic test_ts();
        logic [15:0] t0;
        do_reset();
        push_evt(8'h01);
        t0 = evt_ts;
        repeat (9) tick();
        push_evt(8'h02);
        evt_ready = 1;
        tick();
        evt_ready = 0;
        n_chk++; if (evt_ts - t0 !== 16'd10) begin n_fail++; $display("FAIL ts_delta got %0d exp 10", evt_ts - t0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_both_min();
        test_overflow();
        test_full_push_pop();
        test_empty_push_pop();
        test_seq_wrap();
        test_reset_mid();
`ifdef TICK_EVT_TS_EN
        test_ts();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/tick_event_fifo.md
TICK_EVENT_FIFO -- requirements
Module: tick_event_fifo

Interface
REQ-001 The module SHALL have parameter N, default 8, meaning the width of the counter value.
REQ-002 The module SHALL have parameter DEPTH, default 8, meaning the number of FIFO entries; it SHALL be a power of two and at least 2.
REQ-003 The module SHALL have parameter SEQ_W, default 8, meaning the width of the event sequence number.
REQ-004 The module SHALL have parameter TS_W, default 16, meaning the timestamp width; it SHALL be used only with TICK_EVT_TS_EN.
REQ-005 The module SHALL have port clk, input, width 1: the single clock; all logic SHALL be on its rising edge.
REQ-006 The module SHALL have port rst_n, input, width 1: asynchronous, active-low reset.
REQ-007 The module SHALL have port cnt_in, input, width N: the upstream counter's registered output value.
REQ-008 The module SHALL have ports max_tick and min_tick, input, width 1 each: the upstream counter's wrap pulses.
REQ-009 The module SHALL have port evt_valid, output, width 1: high when a head entry is available.
REQ-010 The module SHALL have port evt_ready, input, width 1: consumer accepts the head entry.
REQ-011 The module SHALL have port evt_type, output, width 2: type of the head entry.
REQ-012 The module SHALL have port evt_cnt, output, width N: captured cnt_in for the head entry.
REQ-013 The module SHALL have port evt_seq, output, width SEQ_W: sequence number of the head entry.
REQ-014 The module SHALL have port level, output, width $clog2(DEPTH)+1: current occupancy.
REQ-015 The module SHALL have ports full and empty, output, width 1 each: occupancy flags.
REQ-016 The module SHALL have port overflow, output, width 1: sticky flag for a dropped event.
REQ-017 The module SHALL have port clr_ovf, input, width 1: synchronous clear of overflow.

Function
REQ-018 The module SHALL detect an event in any cycle with max_tick or min_tick high, and SHALL assign its type as follows: MAX=1 for max_tick only, MIN=2 for min_tick only, BOTH=3 for both, with a single entry written for BOTH.
REQ-019 On each event, the module SHALL capture cnt_in and the current sequence counter in the same cycle, and the entry SHALL be visible at the outputs with evt_valid high on the next cycle (latency 1).
REQ-020 The sequence counter SHALL increment by 1 on every detected event, including dropped ones, and SHALL wrap modulo 2^SEQ_W.
REQ-021 The FIFO SHALL be first-word-fall-through; a pop SHALL occur in any cycle with evt_valid and evt_ready both high.
REQ-022 When the FIFO is empty, evt_valid SHALL be 0, and evt_type, evt_cnt and evt_seq SHALL be 0.
REQ-023 An event arriving while the FIFO is full with no pop in the same cycle SHALL be dropped, SHALL leave the FIFO contents unchanged, and SHALL set overflow to 1.
REQ-024 When a push and a pop occur in the same cycle while the FIFO is full, the event SHALL be accepted, level SHALL be unchanged and overflow SHALL NOT be set.
REQ-025 When a push and a pop occur in the same cycle while the FIFO is empty, no pop SHALL occur, the push SHALL proceed and level SHALL become 1.
REQ-026 When clr_ovf and an overflow occur in the same cycle, overflow SHALL be set (set takes priority over clear).
REQ-027 The read and write pointers SHALL be $clog2(DEPTH)+1 bits wide and wrap naturally; full SHALL be asserted when level equals DEPTH, and empty when level equals 0.

Reset
REQ-028 Assertion of rst_n SHALL immediately clear the pointers, level, sequence counter, overflow and timestamp, and SHALL drive evt_valid to 0, empty to 1 and full to 0.
REQ-029 A reset asserted mid-operation SHALL discard all stored entries, and the storage array itself SHALL NOT require reset.

Configuration
REQ-030 When the macro TICK_EVT_TS_EN is defined, the module SHALL include a free-running TS_W-bit timestamp counter that resets to 0, increments every cycle and wraps, and SHALL capture its value with each entry.
REQ-031 When TICK_EVT_TS_EN is defined, the module SHALL present the captured value on the additional output port evt_ts, width TS_W, which SHALL be 0 when the FIFO is empty.
REQ-032 When TICK_EVT_TS_EN is not defined, the evt_ts port, the timestamp counter and the timestamp storage SHALL be absent.

Structure
REQ-033 A shared package tick_evt_pkg SHALL hold the 2-bit event type enum (NONE=0, MAX=1, MIN=2, BOTH=3) and the default parameter constants.
REQ-034 The design SHALL include one sub-module, tick_evt_mem, implementing the storage: DEPTH x entry-width, one write port, and a combinational read port.

Verification
REQ-035 Single event: with cnt_in=8'hFF, max_tick pulsed once and evt_ready=0, the next cycle SHALL show evt_valid=1, type=1, cnt=8'hFF, seq=0 and level=1.
REQ-036 Both ticks: with max_tick and min_tick high together and cnt_in=8'h00, there SHALL be exactly one entry with type=3 and level=1.
REQ-037 Overflow: after 9 events with DEPTH=8 and no reads, the FIFO SHALL report full=1, level=8 and overflow=1; the stored seq values SHALL be 0..7; and the next event accepted after one pop SHALL carry seq=9.
REQ-038 Full push+pop: with the FIFO full, an event and evt_ready=1 in the same cycle SHALL leave level at 8, keep overflow at 0, and advance the head seq by 1.
REQ-039 Reset mid-operation: with level=5, asserting rst_n low SHALL immediately give evt_valid=0 and empty=1, and the first event after release SHALL carry seq=0.
REQ-040 Timestamp (TICK_EVT_TS_EN defined): two events captured 10 cycles apart SHALL have evt_ts values that differ by exactly 10.
